// File: rtl/cordic_pkg.sv
// Shared widths, mode encodings, FSM states, the arctangent table and the
// output saturation helper for the CORDIC engine.
package cordic_pkg;

  localparam int IN_W  = 18;
  localparam int OUT_W = 19;
  localparam int INT_W = 20;
  localparam int ANG_W = 18;

  localparam logic MODE_ROT = 1'b0;
  localparam logic MODE_VEC = 1'b1;

  localparam int ANG_180 = 131072;
  localparam int ANG_90  = 65536;

  // Angle constants in register width; 180 deg is the 18-bit pattern 0x20000.
  localparam logic [ANG_W-1:0]        ANG_180_W = 18'h20000;
  localparam logic signed [ANG_W-1:0] ANG_90_P  = 18'sd65536;
  localparam logic signed [ANG_W-1:0] ANG_90_N  = -18'sd65536;

  // Saturation limits of the 19-bit signed result, held in internal width.
  localparam logic signed [INT_W-1:0] SAT_HI = 20'sd262143;
  localparam logic signed [INT_W-1:0] SAT_LO = -20'sd262144;

  // atan(2^-i) in binary-angle units (2^17 = 180 deg).
  localparam logic [ANG_W-1:0] ATAN_LUT [0:15] = '{
    18'd32768, 18'd19344, 18'd10221, 18'd5188, 18'd2604, 18'd1303,
    18'd652,   18'd326,   18'd163,   18'd81,   18'd41,   18'd20,
    18'd10,    18'd5,     18'd3,     18'd1
  };

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FIN
  } state_t;

  // Clamp an internal-width value into the 19-bit signed output range.
  function automatic logic signed [OUT_W-1:0] sat_out(input logic signed [INT_W-1:0] v);
    logic signed [INT_W-1:0] c;
    if (v > SAT_HI)      c = SAT_HI;
    else if (v < SAT_LO) c = SAT_LO;
    else                 c = v;
    return c[OUT_W-1:0];
  endfunction

endpackage

// File: rtl/cordic_atan_lut.sv
// Combinational ROM: iteration index -> atan(2^-idx) in binary-angle units.
module cordic_atan_lut
  import cordic_pkg::*;
(
  input  logic [3:0]       idx,
  output logic [ANG_W-1:0] angle
);

  assign angle = ATAN_LUT[idx];

endmodule

// File: rtl/cordic_engine.sv
// Iterative circular CORDIC: one micro-rotation per clock, rotation or
// vectoring mode, quadrant pre-rotation at load, raw gain on x/y.
module cordic_engine
  import cordic_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic signed [IN_W-1:0]  x0,
  input  logic signed [IN_W-1:0]  y0,
  input  logic signed [ANG_W-1:0] z0,
  input  logic                    rot0_vec1,
  input  logic [3:0]              n_iter,
  output logic                    done,
  output logic                    busy,
  output logic signed [OUT_W-1:0] xn,
  output logic signed [OUT_W-1:0] yn,
  output logic signed [ANG_W-1:0] zn
);

  state_t                  state_q, state_d;
  logic signed [INT_W-1:0] x_q, x_d, y_q, y_d;
  logic [ANG_W-1:0]        z_q, z_d;
  logic                    mode_q, mode_d;
  logic [3:0]              i_q, i_d, n_iter_q, n_iter_d;
  logic signed [OUT_W-1:0] xn_q, xn_d, yn_q, yn_d;
  logic [ANG_W-1:0]        zn_q, zn_d;
  logic                    done_q, done_d, busy_q, busy_d;

  logic [ANG_W-1:0]        atan_i;
  logic signed [INT_W-1:0] x0_ext, y0_ext, x_pre, y_pre;
  logic [ANG_W-1:0]        z_pre;
  logic                    flip;
  logic signed [INT_W-1:0] x_sh, y_sh;
  logic                    d_pos;
  logic [4:0]              i_next;

  cordic_atan_lut u_lut (
    .idx   (i_q),
    .angle (atan_i)
  );

  // Fold the load operands into the convergence range (right half-plane / |z| <= 90 deg).
  always_comb begin
    // NOTE: every variable written here gets a value on every path first, otherwise a latch is inferred.
    x0_ext = {{(INT_W-IN_W){x0[IN_W-1]}}, x0};
    y0_ext = {{(INT_W-IN_W){y0[IN_W-1]}}, y0};
    flip   = 1'b0;
    z_pre  = z0;
    if (rot0_vec1 == MODE_VEC) begin
      flip = x0[IN_W-1];
      if (flip) z_pre = z0 + ANG_180_W;
    end else begin
      flip = (z0 > ANG_90_P) || (z0 < ANG_90_N);
      if (flip) z_pre = z0 - ANG_180_W;
    end
    x_pre = flip ? -x0_ext : x0_ext;
    y_pre = flip ? -y0_ext : y0_ext;
  end

  // Shifted operands and micro-rotation direction for the current iteration.
  always_comb begin
    x_sh   = x_q >>> i_q;
    y_sh   = y_q >>> i_q;
    d_pos  = (mode_q == MODE_ROT) ? ~z_q[ANG_W-1] : y_q[INT_W-1];
    i_next = {1'b0, i_q} + 5'd1;
  end

  // FSM next state, datapath update and output capture.
  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    z_d      = z_q;
    mode_d   = mode_q;
    i_d      = i_q;
    n_iter_d = n_iter_q;
    xn_d     = xn_q;
    yn_d     = yn_q;
    zn_d     = zn_q;
    done_d   = 1'b0;
    busy_d   = busy_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          x_d      = x_pre;
          y_d      = y_pre;
          z_d      = z_pre;
          mode_d   = rot0_vec1;
          n_iter_d = n_iter;
          i_d      = 4'd0;
          if (n_iter == 4'd0) begin
            state_d = ST_FIN;
            busy_d  = 1'b0;
          end else begin
            state_d = ST_RUN;
            busy_d  = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (d_pos) begin
          x_d = x_q - y_sh;
          y_d = y_q + x_sh;
          z_d = z_q - atan_i;
        end else begin
          x_d = x_q + y_sh;
          y_d = y_q - x_sh;
          z_d = z_q + atan_i;
        end
        i_d = i_next[3:0];
        if (i_next == {1'b0, n_iter_q}) begin
          state_d = ST_FIN;
          busy_d  = 1'b0;
        end
      end
      ST_FIN: begin
        xn_d    = sat_out(x_q);
        yn_d    = sat_out(y_q);
        zn_d    = z_q;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any job in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      x_q      <= '0;
      y_q      <= '0;
      z_q      <= '0;
      mode_q   <= MODE_ROT;
      i_q      <= '0;
      n_iter_q <= '0;
      xn_q     <= '0;
      yn_q     <= '0;
      zn_q     <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values.
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      z_q      <= z_d;
      mode_q   <= mode_d;
      i_q      <= i_d;
      n_iter_q <= n_iter_d;
      xn_q     <= xn_d;
      yn_q     <= yn_d;
      zn_q     <= zn_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign done = done_q;
  assign busy = busy_q;
  assign xn   = xn_q;
  assign yn   = yn_q;
  assign zn   = zn_q;

endmodule

// File: tb/tb_cordic_engine.sv
// Scoreboard bench for cordic_engine: directed jobs push expected results,
// an independent monitor pops and compares on every done pulse.
module tb_cordic_engine;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic signed [17:0] x0, y0, z0;
  logic               rot0_vec1;
  logic [3:0]         n_iter;
  logic               done, busy;
  logic signed [18:0] xn, yn;
  logic signed [17:0] zn;

  cordic_engine dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .x0        (x0),
    .y0        (y0),
    .z0        (z0),
    .rot0_vec1 (rot0_vec1),
    .n_iter    (n_iter),
    .done      (done),
    .busy      (busy),
    .xn        (xn),
    .yn        (yn),
    .zn        (zn)
  );

  always #5 clk = ~clk;

  // Free-running count of rising edges, used to check done latency.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string name;
    int    x, y, z;
    int    tx, ty, tz;
    int    due;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks  = 0;
  int   errors  = 0;
  int   overlap = 0;

  task automatic check(input string name, input int act, input int exp, input int tol);
    checks++;
    if ((act - exp > tol) || (exp - act > tol)) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (tol %0d)", name, act, exp, tol);
    end
  endtask

  // Monitor: compare each done pulse against the oldest expected job.
  always @(negedge clk) begin
    if (busy && done) overlap++;
    if (done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done at cycle %0d, expected none", cyc);
      end else begin
        mon_e = sb.pop_front();
        check({mon_e.name, "_latency"}, cyc, mon_e.due, 0);
        check({mon_e.name, "_xn"}, xn, mon_e.x, mon_e.tx);
        check({mon_e.name, "_yn"}, yn, mon_e.y, mon_e.ty);
        check({mon_e.name, "_zn"}, zn, mon_e.z, mon_e.tz);
      end
    end
  end

  // Issue one job on the next falling edge and record what it must produce.
  task automatic launch(input string nm, input int xi, input int yi, input int zi,
                        input logic m, input int n,
                        input int ex, input int ey, input int ez,
                        input int tx, input int ty, input int tz);
    exp_t e;
    @(negedge clk);
    x0        = xi[17:0];
    y0        = yi[17:0];
    z0        = zi[17:0];
    rot0_vec1 = m;
    n_iter    = n[3:0];
    start     = 1'b1;
    e.name = nm; e.x = ex; e.y = ey; e.z = ez;
    e.tx = tx; e.ty = ty; e.tz = tz;
    e.due = cyc + n + 2;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Wait for all outstanding jobs, bounded by a cycle budget.
  task automatic drain(input int budget);
    int k = 0;
    while (sb.size() != 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (sb.size() != 0) begin
      check("drain_timeout", sb.size(), 0, 0);
      sb.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200000, expected earlier finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; x0 = '0; y0 = '0; z0 = '0; rot0_vec1 = 1'b0; n_iter = '0;
    repeat (2) @(negedge clk);
    check("reset_busy", int'(busy), 0, 0);
    check("reset_done", int'(done), 0, 0);
    check("reset_xn", xn, 0, 0);
    rst = 1'b0;

    // Rotation, 11.25 deg on x = 0.5: K*0.5*(cos, sin).
    launch("rot_small", 32768, 0, 8192, 1'b0, 15, 52924, 10527, 0, 16, 16, 4);
    drain(40);
    // Vectoring from the third quadrant: magnitude*K, angle -126.87 deg.
    launch("vec_neg", -39322, -52429, 0, 1'b1, 15, 107922, 0, -92384, 16, 16, 8);
    drain(40);
    // Rotation by 135 deg needs the pre-rotation.
    launch("rot_135", 65536, 0, 98304, 1'b0, 15, -76312, 76312, 0, 16, 16, 8);
    drain(40);
    // Vectoring near full scale: xn clamps to the 19-bit maximum.
    launch("vec_sat", 131071, 131071, 0, 1'b1, 15, 262143, 0, 32768, 0, 32, 8);
    drain(40);

    // n_iter = 0: outputs are the (pre-rotated) load values, one cycle later.
    launch("n0_rot_in", 12345, -6789, 65536, 1'b0, 0, 12345, -6789, 65536, 0, 0, 0);
    drain(10);
    launch("n0_rot_out", 1000, 2000, 65537, 1'b0, 0, -1000, -2000, -65535, 0, 0, 0);
    drain(10);
    launch("n0_rot_neg", -5000, 7000, -100000, 1'b0, 0, 5000, -7000, 31072, 0, 0, 0);
    drain(10);
    launch("n0_vec_neg", -1000, 500, 0, 1'b1, 0, 1000, -500, -131072, 0, 0, 0);
    drain(10);
    launch("n0_vec_min", -131072, 0, 100, 1'b1, 0, 131072, 0, -130972, 0, 0, 0);
    drain(10);

    // One iteration: z >= 0 rotates by +45 deg.
    launch("n1_rot", 65536, 0, 0, 1'b0, 1, 65536, 65536, -32768, 0, 0, 0);
    drain(10);
    repeat (4) @(negedge clk);
    check("hold_xn", xn, 65536, 0);
    check("hold_zn", zn, -32768, 0);

    // start during RUN must be ignored: exactly one done for this job.
    launch("ignore_start", 32768, 0, 8192, 1'b0, 15, 52924, 10527, 0, 16, 16, 4);
    repeat (3) @(negedge clk);
    x0 = 18'sd1000; y0 = 18'sd0; z0 = 18'sd0; n_iter = 4'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain(40);
    repeat (20) @(negedge clk);

    // Reset during iteration 5 aborts the job and clears the outputs at once.
    launch("aborted", 65536, 0, 98304, 1'b0, 15, 0, 0, 0, 0, 0, 0);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_busy", int'(busy), 0, 0);
    check("abort_done", int'(done), 0, 0);
    check("abort_xn", xn, 0, 0);
    check("abort_yn", yn, 0, 0);
    check("abort_zn", zn, 0, 0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);

    launch("after_reset", 65536, 0, 98304, 1'b0, 15, -76312, 76312, 0, 16, 16, 8);
    drain(40);

    check("busy_done_overlap", overlap, 0, 0);
    check("scoreboard_empty", sb.size(), 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
